// File: rtl/per_bus_pkg.sv
// Shared types for the peripheral bus master: bus widths, FSM states and the
// command word that is buffered in the command FIFO.
package per_bus_pkg;

   localparam int unsigned PER_AW = 14;
   localparam int unsigned PER_DW = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_e;

   typedef struct packed {
      logic              write;
      logic [PER_AW-1:0] addr;
      logic [PER_DW-1:0] wdata;
      logic [1:0]        be;
   } per_cmd_t;

   // Reads must never present byte enables on the bus.
   function automatic logic [1:0] bus_we(input per_cmd_t cmd);
      return cmd.write ? cmd.be : 2'b00;
   endfunction

endpackage

// File: rtl/per_cmd_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit to tell
// full from empty.
module per_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic [7:0]
) (
   input  logic mclk,
   input  logic puc_rst_n,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam logic [IW:0] PTR_ONE = 1;

   logic [IW:0] wr_ptr_q;
   logic [IW:0] rd_ptr_q;
   T            mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge mclk) begin
      if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q[IW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                  (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

endmodule

// File: rtl/per_bus_master.sv
// Peripheral bus initiator: queued commands are issued one bus cycle each,
// reads return on a valid/ready port. Optional counters: PER_BUS_MASTER_STATS_EN.
module per_bus_master
   import per_bus_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned AW         = PER_AW,
   parameter int unsigned DW         = PER_DW
) (
   input  logic          mclk,
   input  logic          puc_rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   input  logic [1:0]    cmd_be,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic [AW-1:0] per_addr,
   output logic [DW-1:0] per_din,
   output logic          per_en,
   output logic [1:0]    per_we,
   input  logic [DW-1:0] per_dout,
`ifdef PER_BUS_MASTER_STATS_EN
   output logic [15:0]   stat_wr_cnt,
   output logic [15:0]   stat_rd_cnt,
`endif
   output logic          busy
);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic [1:0]    we_q, we_d;
   logic          en_q, en_d;
   logic          is_wr_q, is_wr_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rdy_en_q;

   per_cmd_t cmd_in;
   per_cmd_t head;
   logic     fifo_full;
   logic     fifo_empty;
   logic     fifo_pop;
   logic     load;

   always_comb begin
      cmd_in.write = cmd_write;
      cmd_in.addr  = cmd_addr;
      cmd_in.wdata = cmd_wdata;
      cmd_in.be    = cmd_be;
   end

   // Held low until the first edge after reset so cmd_ready is 0 in reset.
   assign cmd_ready = rdy_en_q & ~fifo_full;

   per_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (per_cmd_t)
   ) u_fifo (
      .mclk      (mclk),
      .puc_rst_n (puc_rst_n),
      .push      (cmd_valid & cmd_ready),
      .push_data (cmd_in),
      .pop       (fifo_pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      din_d       = din_q;
      we_d        = we_q;
      en_d        = 1'b0;
      is_wr_d     = is_wr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         ISSUE: begin
            if (is_wr_q) begin
               if (!fifo_empty) load = 1'b1;
               else             state_d = IDLE;
            end else begin
               rsp_rdata_d = per_dout;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (!fifo_empty) load = 1'b1;
               else             state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         addr_d  = head.addr;
         din_d   = head.wdata;
         we_d    = bus_we(head);
         is_wr_d = head.write;
         en_d    = 1'b1;
         state_d = ISSUE;
      end
      fifo_pop = load;
   end

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         we_q        <= 2'b00;
         en_q        <= 1'b0;
         is_wr_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         we_q        <= we_d;
         en_q        <= en_d;
         is_wr_q     <= is_wr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rdy_en_q    <= 1'b1;
      end
   end

   assign per_addr  = addr_q;
   assign per_din   = din_q;
   assign per_we    = we_q;
   assign per_en    = en_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = ~fifo_empty | (state_q != IDLE);

`ifdef PER_BUS_MASTER_STATS_EN
   logic [15:0] stat_wr_cnt_q;
   logic [15:0] stat_rd_cnt_q;

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         stat_wr_cnt_q <= 16'h0000;
         stat_rd_cnt_q <= 16'h0000;
      end else if (en_q) begin
         if (is_wr_q) stat_wr_cnt_q <= stat_wr_cnt_q + 16'h0001;
         else         stat_rd_cnt_q <= stat_rd_cnt_q + 16'h0001;
      end
   end

   assign stat_wr_cnt = stat_wr_cnt_q;
   assign stat_rd_cnt = stat_rd_cnt_q;
`endif

endmodule

// File: doc/per_bus_master.md
Name: per_bus_master

Overview:
- Initiator for the 14-bit word-addressed peripheral bus: drives per_addr/per_din/per_en/per_we and samples per_dout.
- Lets a hardware client (test sequencer, future DMA) program bus peripherals such as the multiply accelerator without the CPU.
- Commands enter through a valid/ready port and are buffered in a small FIFO. They are issued one bus cycle each. Reads return data on a valid/ready response port.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- AW, 14, peripheral word-address width.
- DW, 16, data width.

Ports:
- mclk  in  1  system clock; all logic on posedge.
- puc_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !fifo_full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  target word address.
- cmd_wdata  in  DW  write data; ignored for reads.
- cmd_be  in  2  byte enables for writes; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  client accepts response.
- rsp_rdata  out  DW  captured read data.
- per_addr  out  AW  bus address, registered.
- per_din  out  DW  bus write data, registered.
- per_en  out  1  bus access strobe, registered.
- per_we  out  2  byte write enables, registered; 2'b00 on reads.
- per_dout  in  DW  bus read data, combinational from responders (OR-ed bus).
- busy  out  1  FIFO non-empty, or state other than IDLE.

Behaviour:
- Reset (async, puc_rst_n=0): all outputs 0, FIFO emptied, state IDLE. cmd_ready rises the first cycle after reset release.
- Reset mid-operation: the in-flight access is aborted, per_en drops immediately, queued commands and any pending response are discarded.
- Accept: a command is pushed on the posedge where cmd_valid & cmd_ready.
  - Full FIFO: cmd_ready=0, even if a pop occurs in the same cycle. A simultaneous push and pop on a non-full FIFO is legal.
- FIFO is show-ahead. Pointers are (log2 DEPTH)+1 bits wide and wrap naturally.
- Command latency from an empty FIFO:
  - accept at edge 0, per_en high in the cycle after edge 1.
  - For a read, rsp_valid is high in the cycle after edge 2.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - FIFO non-empty: pop the head and load per_addr, per_din and per_we (cmd_be for writes, 00 for reads); set per_en=1; go to ISSUE.
  - Otherwise per_en=0.
- ISSUE: per_en is high for exactly this one cycle.
  - Write + FIFO non-empty: pop the next command and reload the bus registers. Back-to-back accesses are allowed, with per_en held high continuously.
  - Write + FIFO empty: per_en=0, go to IDLE.
  - Read: capture per_dout into rsp_rdata at the edge ending ISSUE, set rsp_valid=1, per_en=0, go to RESP. Reads are never pipelined with a following access.
- RESP: hold rsp_valid and rsp_rdata stable until rsp_valid & rsp_ready.
  - On that edge, clear rsp_valid. If the FIFO is non-empty, issue the head command as in IDLE; otherwise go to IDLE.
  - No bus activity while in RESP; commands keep queuing.
- per_addr, per_din and per_we hold their last values when per_en=0. Responders must qualify on per_en.
- Write commands produce no response.
- Zero-data reads are legal: unmapped addresses return 16'h0.

Optional Feature:
- Macro: PER_BUS_MASTER_STATS_EN.
- Defined: adds outputs stat_wr_cnt[15:0] and stat_rd_cnt[15:0].
  - Each increments on every issued write or read bus cycle respectively (per_en high).
  - Both wrap 16'hFFFF to 0 and reset to 0.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package per_bus_pkg:
  - PER_AW=14 and PER_DW=16;
  - state enum {IDLE, ISSUE, RESP};
  - packed command struct {write, addr, wdata, be}, which is the FIFO word.
- Sub-module per_cmd_fifo: synchronous FIFO parameterised by depth and word type, with push/pop/full/empty and show-ahead head data.
- The FSM and bus registers live in the top module.

Test Plan:
- Multiply bring-up, with a bench model of the multiply accelerator:
  - writes (A0, 0003), (A1, 0005), (A4, 0001), (A4, 0000), then read A2 → rsp_rdata=000F;
  - read A3 → 0000;
  - the first three writes show per_en high on 3 consecutive cycles.
- Byte write: write A0 data 12AB be=01 → per_we=01 for one cycle. Read at an unmapped address 55 → rsp_rdata=0000.
- Backpressure:
  - Sequence: read A2, then write A0; hold rsp_ready=0 for 10 cycles.
  - Required: rsp_valid stays 1 and rsp_rdata stays stable; the write is not issued until the cycle after the rsp handshake.
- FIFO full:
  - Stall with rsp_ready=0 after a read, then push FIFO_DEPTH commands.
  - Required: cmd_ready=0 after the 4th push, and returns to 1 the cycle after the first pop.
- Reset mid-op: assert puc_rst_n=0 during ISSUE of a read with 3 commands queued → per_en=0 and rsp_valid=0 immediately; busy=0 after release, no further bus cycles.
- With PER_BUS_MASTER_STATS_EN: run 5 writes and 2 reads → stat_wr_cnt=5, stat_rd_cnt=2. Preload the counter to FFFF via force, then one more write → stat_wr_cnt wraps to 0000.
